// File: rtl/regblock_seq.sv
// regblock_seq: multi-cycle 16-bit instruction sequencer mastering the register file.
// Build option: define REGBLOCK_SEQ_STATS_EN for the retired-instruction counter.
module regblock_seq #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   in_instr,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_iaddr,
  output logic [DW-1:0] rf_idata,
  output logic          rf_oe,
  output logic [AW-1:0] rf_oaddr,
  input  logic [DW-1:0] rf_odata,
  input  logic [DW-1:0] rf_rega,
  input  logic [DW-1:0] rf_regb,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          flag_c,
  output logic          flag_z,
  output logic          halted,
  input  logic          resume,
  output logic          err,
  output logic [15:0]   instr_count
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, WB, ALU, OUTW, HALT
  } state_t;

  state_t state, state_n;

  logic [3:0]    op;
  logic [AW-1:0] dst, src;
  logic [DW-1:0] imm;
  logic          accept;
  logic          is_nop, is_ldi, is_mov, is_add;
  logic          is_sub, is_out, is_hlt, is_ill;
  logic [DW:0]   sum, dif;
  logic          rd_out;
  logic          c_pend;

  assign op  = in_instr[15:12];
  assign dst = in_instr[9 +: AW];
  assign src = in_instr[6 +: AW];
  assign imm = DW'(in_instr[7:0]);

  assign is_nop = op == 4'h0;
  assign is_ldi = op == 4'h1;
  assign is_mov = op == 4'h2;
  assign is_add = op == 4'h3;
  assign is_sub = op == 4'h4;
  assign is_out = op == 4'h5;
  assign is_hlt = op == 4'h6;
  assign is_ill = op > 4'h6;

  assign accept = in_valid && (state == IDLE);

  // top bit is carry for ADD, borrow for SUB
  assign sum = {1'b0, rf_rega} + {1'b0, rf_regb};
  assign dif = {1'b0, rf_rega} - {1'b0, rf_regb};

  assign in_ready = state == IDLE;
  assign halted   = state == HALT;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_ldi:         state_n = WR;
            is_mov, is_out: state_n = RD;
            is_add, is_sub: state_n = ALU;
            is_hlt:         state_n = HALT;
            default:        state_n = IDLE;
          endcase
        end
      end
      WR, WB, ALU: state_n = IDLE;
      RD:          state_n = rd_out ? OUTW : WB;
      OUTW:        if (out_ready) state_n = IDLE;
      HALT:        if (resume) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_iaddr  <= '0;
      rf_idata  <= '0;
      rf_oe     <= 1'b0;
      rf_oaddr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      err       <= 1'b0;
      rd_out    <= 1'b0;
      c_pend    <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      rf_oe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rf_iaddr <= dst;
            rf_oaddr <= src;
            rd_out   <= is_out;
            rf_we    <= is_ldi | is_add | is_sub;
            rf_oe    <= is_mov | is_out;
            err      <= err | is_ill;
            if (is_ldi) rf_idata <= imm;
            if (is_add) {c_pend, rf_idata} <= sum;
            if (is_sub) {c_pend, rf_idata} <= dif;
          end
        end
        RD: begin
          if (rd_out) begin
            out_data  <= rf_odata;
            out_valid <= 1'b1;
          end else begin
            rf_idata <= rf_odata;
            rf_we    <= 1'b1;
          end
        end
        // flags land on the same edge the register file takes the result
        ALU: begin
          flag_c <= c_pend;
          flag_z <= rf_idata == '0;
        end
        OUTW: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef REGBLOCK_SEQ_STATS_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    unique case (state)
      IDLE:        retire = accept && (is_nop || is_ill || is_hlt);
      WR, WB, ALU: retire = 1'b1;
      OUTW:        retire = out_ready;
      default:     retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         instr_count <= '0;
    else if (retire) instr_count <= instr_count + 16'd1;
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_regblock_seq.sv
// tb_regblock_seq: directed and randomized checks of regblock_seq
// against a register-file environment and an instruction-level model.
module tb_regblock_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, resume;
  logic [15:0] in_instr;
  logic        in_ready, rf_we, rf_oe, out_valid;
  logic [2:0]  rf_iaddr, rf_oaddr;
  logic [7:0]  rf_idata, rf_odata, rf_rega, rf_regb, out_data;
  logic        flag_c, flag_z, halted, err;
  logic [15:0] instr_count;

  logic [7:0]  mem [8];
  logic        mem_clr;
  logic [7:0]  ref_r [8];
  logic        ref_c, ref_z;
  int          retired;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  regblock_seq #(.DW(8), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .rf_we(rf_we), .rf_iaddr(rf_iaddr), .rf_idata(rf_idata),
    .rf_oe(rf_oe), .rf_oaddr(rf_oaddr), .rf_odata(rf_odata),
    .rf_rega(rf_rega), .rf_regb(rf_regb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flag_c(flag_c), .flag_z(flag_z), .halted(halted),
    .resume(resume), .err(err), .instr_count(instr_count)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (rf_we) begin
      mem[rf_iaddr] <= rf_idata;
    end
  end

  assign rf_odata = rf_oe ? mem[rf_oaddr] : 8'h00;
  assign rf_rega  = mem[0];
  assign rf_regb  = mem[1];

  function automatic logic [15:0] exp_cnt();
`ifdef REGBLOCK_SEQ_STATS_EN
    return retired[15:0];
`else
    return 16'd0;
`endif
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_wait in_ready=%b want=1", in_ready);
    end
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
    retired++;
  endtask

  task automatic ldi(input logic [2:0] d, input logic [7:0] v);
    issue({4'h1, d, 1'b0, v});
    ref_r[d] = v;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_clr = 1'b1; in_valid = 1'b0;
    out_ready = 1'b0; resume = 1'b0; in_instr = 16'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({rf_we, rf_oe, out_valid, halted, err, flag_c, flag_z} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0",
        {rf_we, rf_oe, out_valid, halted, err, flag_c, flag_z});
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", in_ready);
    end
    total++;
    if ({rf_iaddr, rf_oaddr, rf_idata, out_data} !== 22'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0",
        {rf_iaddr, rf_oaddr, rf_idata, out_data});
    end
    total++;
    if (instr_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", instr_count);
    end
    rst = 1'b0; mem_clr = 1'b0;
    for (int i = 0; i < 8; i++) ref_r[i] = 8'h00;
    ref_c = 1'b0; ref_z = 1'b0; retired = 0;
  endtask

  task automatic test_ldi;
    issue(16'h16A5);
    ref_r[3] = 8'hA5;
    total++;
    if ({rf_we, rf_iaddr, rf_idata, in_ready} !== {1'b1, 3'd3, 8'hA5, 1'b0}) begin
      bad++;
      $display("FAIL ldi_wr got=%h want=%h",
        {rf_we, rf_iaddr, rf_idata, in_ready}, {1'b1, 3'd3, 8'hA5, 1'b0});
    end
    @(negedge clk);
    total++;
    if ({in_ready, rf_we} !== 2'b10) begin
      bad++;
      $display("FAIL ldi_idle got=%b want=10", {in_ready, rf_we});
    end
  endtask

  task automatic test_add_sub;
    int a, b;
    logic [7:0] r;
    ldi(3'd0, 8'hF0);
    ldi(3'd1, 8'h20);
    issue(16'h3400);
    a = ref_r[0]; b = ref_r[1];
    r = 8'((a + b) % 256);
    ref_c = (a + b) > 255; ref_z = r == 8'h00; ref_r[2] = r;
    total++;
    if ({rf_we, rf_iaddr, rf_idata} !== {1'b1, 3'd2, r}) begin
      bad++;
      $display("FAIL add_wr got=%h want=%h", {rf_we, rf_iaddr, rf_idata}, {1'b1, 3'd2, r});
    end
    @(negedge clk);
    total++;
    if ({flag_c, flag_z} !== {ref_c, ref_z}) begin
      bad++;
      $display("FAIL add_flags got=%b want=%b", {flag_c, flag_z}, {ref_c, ref_z});
    end
    ldi(3'd0, 8'h20);
    issue(16'h4400);
    a = ref_r[0]; b = ref_r[1];
    r = 8'((a - b) & 255);
    ref_c = a < b; ref_z = r == 8'h00; ref_r[2] = r;
    total++;
    if ({rf_we, rf_iaddr, rf_idata} !== {1'b1, 3'd2, r}) begin
      bad++;
      $display("FAIL sub_wr got=%h want=%h", {rf_we, rf_iaddr, rf_idata}, {1'b1, 3'd2, r});
    end
    @(negedge clk);
    total++;
    if ({flag_c, flag_z} !== {ref_c, ref_z}) begin
      bad++;
      $display("FAIL sub_flags got=%b want=%b", {flag_c, flag_z}, {ref_c, ref_z});
    end
  endtask

  task automatic test_mov;
    issue(16'h2AC0);
    total++;
    if ({rf_oe, rf_oaddr, rf_we} !== {1'b1, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL mov_rd got=%b want=10110", {rf_oe, rf_oaddr, rf_we});
    end
    @(negedge clk);
    total++;
    if ({rf_we, rf_iaddr, rf_idata, rf_oe} !== {1'b1, 3'd5, ref_r[3], 1'b0}) begin
      bad++;
      $display("FAIL mov_wb got=%h want=%h",
        {rf_we, rf_iaddr, rf_idata, rf_oe}, {1'b1, 3'd5, ref_r[3], 1'b0});
    end
    ref_r[5] = ref_r[3];
  endtask

  task automatic test_out;
    out_ready = 1'b0;
    issue(16'h50C0);
    total++;
    if ({rf_oe, rf_oaddr} !== {1'b1, 3'd3}) begin
      bad++;
      $display("FAIL out_rd got=%b want=1011", {rf_oe, rf_oaddr});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_data, in_ready} !== {1'b1, ref_r[3], 1'b0}) begin
        bad++;
        $display("FAIL out_hold%0d got=%h want=%h", i,
          {out_valid, out_data, in_ready}, {1'b1, ref_r[3], 1'b0});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL out_done got=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_illegal_halt;
    issue(16'h9000);
    total++;
    if ({err, rf_we, in_ready} !== 3'b101) begin
      bad++;
      $display("FAIL illegal got=%b want=101", {err, rf_we, in_ready});
    end
    issue(16'h6000);
    total++;
    if ({halted, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL halt_enter got=%b want=10", {halted, in_ready});
    end
    in_valid = 1'b1; in_instr = 16'h1055;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({halted, rf_we, in_ready} !== 3'b100) begin
        bad++;
        $display("FAIL halt_hold%0d got=%b want=100", i, {halted, rf_we, in_ready});
      end
    end
    in_valid = 1'b0; resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    total++;
    if ({halted, in_ready, err} !== 3'b011) begin
      bad++;
      $display("FAIL halt_resume got=%b want=011", {halted, in_ready, err});
    end
    total++;
    if (instr_count !== exp_cnt()) begin
      bad++;
      $display("FAIL count_mid got=%0d want=%0d", instr_count, exp_cnt());
    end
  endtask

  task automatic test_reset_mid;
    logic saw;
    issue(16'h2CC0);
    total++;
    if (rf_oe !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_rd got=%b want=1", rf_oe);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({rf_we, rf_oe, out_valid, err, flag_c, flag_z, halted, in_ready} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL rstmid_outs got=%b want=00000001",
        {rf_we, rf_oe, out_valid, err, flag_c, flag_z, halted, in_ready});
    end
    total++;
    if (instr_count !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_count got=%0d want=0", instr_count);
    end
    rst = 1'b0; retired = 0; ref_c = 1'b0; ref_z = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw = saw | rf_we;
    end
    total++;
    if ({saw, mem[6]} !== {1'b0, ref_r[6]}) begin
      bad++;
      $display("FAIL rstmid_nowrite got=%h want=%h", {saw, mem[6]}, {1'b0, ref_r[6]});
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 60; it++) begin
      int k, a, b;
      logic [2:0] d, s;
      logic [7:0] v, r;
      k = $urandom_range(0, 5);
      d = 3'($urandom_range(0, 7));
      s = 3'($urandom_range(0, 7));
      v = 8'($urandom_range(0, 255));
      a = ref_r[0]; b = ref_r[1];
      case (k)
        0: begin
          issue({4'h0, 12'($urandom)});
          total++;
          if ({rf_we, rf_oe, in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL rnd_nop got=%b want=001", {rf_we, rf_oe, in_ready});
          end
        end
        1: begin
          issue({4'h1, d, 1'($urandom), v});
          ref_r[d] = v;
          total++;
          if ({rf_we, rf_iaddr, rf_idata} !== {1'b1, d, v}) begin
            bad++;
            $display("FAIL rnd_ldi got=%h want=%h", {rf_we, rf_iaddr, rf_idata}, {1'b1, d, v});
          end
        end
        2: begin
          issue({4'h2, d, s, 6'($urandom)});
          total++;
          if ({rf_oe, rf_oaddr, rf_we} !== {1'b1, s, 1'b0}) begin
            bad++;
            $display("FAIL rnd_mov_rd got=%b want=%b", {rf_oe, rf_oaddr, rf_we}, {1'b1, s, 1'b0});
          end
          @(negedge clk);
          r = ref_r[s]; ref_r[d] = r;
          total++;
          if ({rf_we, rf_iaddr, rf_idata} !== {1'b1, d, r}) begin
            bad++;
            $display("FAIL rnd_mov_wb got=%h want=%h", {rf_we, rf_iaddr, rf_idata}, {1'b1, d, r});
          end
        end
        3, 4: begin
          issue({(k == 3) ? 4'h3 : 4'h4, d, 9'($urandom)});
          if (k == 3) begin
            r = 8'((a + b) % 256); ref_c = (a + b) > 255;
          end else begin
            r = 8'((a - b) & 255); ref_c = a < b;
          end
          ref_z = r == 8'h00; ref_r[d] = r;
          total++;
          if ({rf_we, rf_iaddr, rf_idata} !== {1'b1, d, r}) begin
            bad++;
            $display("FAIL rnd_alu got=%h want=%h", {rf_we, rf_iaddr, rf_idata}, {1'b1, d, r});
          end
          @(negedge clk);
          total++;
          if ({flag_c, flag_z} !== {ref_c, ref_z}) begin
            bad++;
            $display("FAIL rnd_flags got=%b want=%b", {flag_c, flag_z}, {ref_c, ref_z});
          end
        end
        default: begin
          out_ready = 1'($urandom);
          issue({4'h5, d, s, 6'($urandom)});
          @(negedge clk);
          total++;
          if ({out_valid, out_data} !== {1'b1, ref_r[s]}) begin
            bad++;
            $display("FAIL rnd_out got=%h want=%h", {out_valid, out_data}, {1'b1, ref_r[s]});
          end
          if (!out_ready) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            total++;
            if ({out_valid, out_data} !== {1'b1, ref_r[s]}) begin
              bad++;
              $display("FAIL rnd_out_hold got=%h want=%h", {out_valid, out_data}, {1'b1, ref_r[s]});
            end
            out_ready = 1'b1;
          end
          @(negedge clk);
          out_ready = 1'b0;
          total++;
          if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rnd_out_done got=%b want=01", {out_valid, in_ready});
          end
        end
      endcase
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== ref_r[i]) begin
        bad++;
        $display("FAIL rnd_reg%0d got=%h want=%h", i, mem[i], ref_r[i]);
      end
    end
    total++;
    if (instr_count !== exp_cnt()) begin
      bad++;
      $display("FAIL rnd_count got=%0d want=%0d", instr_count, exp_cnt());
    end
  endtask

  initial begin
    test_reset;
    test_ldi;
    test_add_sub;
    test_mov;
    test_out;
    test_illegal_halt;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
